// File: rtl/regfile_arbiter.sv
// Two-requester round-robin sequencer in front of the 32x32 register file.
// Serialises A/B read/write ops onto the single rf port, one op in flight at a time.
// Every output comes straight from a register; the rf writes on posedge and reads on negedge.
module regfile_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rsp,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rsp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] rf_inp,
  output logic [5:0]        rf_inp_sel,
  output logic [5:0]        rf_out_sel,
  output logic              rf_read,
  output logic              rf_write,
  output logic              rf_EN,
  input  logic [DATA_W-1:0] rf_out
);

  localparam int unsigned SelW = 6;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;    // 1: most recent grant went to B
  logic                owner_b_q, owner_b_d;  // requester of the op in flight
  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                rsp_a_q, rsp_a_d;
  logic                rsp_b_q, rsp_b_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   inp_q, inp_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                en_q, en_d;

  logic                pick_a, pick_b;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    pick_a    = a_req & (~b_req | last_b_q);
    pick_b    = b_req & (~a_req | ~last_b_q);
    win_we    = pick_b ? b_we    : a_we;
    win_addr  = pick_b ? b_addr  : a_addr;
    win_wdata = pick_b ? b_wdata : a_wdata;
  end

  // Next-state and registered-output logic; pulses and rf strobes default low.
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    rsp_a_d   = 1'b0;
    rsp_b_d   = 1'b0;
    rdata_d   = rdata_q;
    inp_d     = inp_q;
    sel_d     = sel_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    en_d      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (pick_a || pick_b) begin
          state_d   = StIssue;
          owner_b_d = pick_b;
          last_b_d  = pick_b;
          gnt_a_d   = pick_a;
          gnt_b_d   = pick_b;
          en_d      = 1'b1;
          write_d   = win_we;
          read_d    = ~win_we;
          sel_d     = {{(SelW - ADDR_W){1'b0}}, win_addr};
          inp_d     = win_wdata;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        // The rf commits a write at this edge; a read's data appeared at the prior negedge.
        state_d = StDone;
        rsp_a_d = ~owner_b_q;
        rsp_b_d = owner_b_q;
        if (read_q) begin
          rdata_d = rf_out;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; async reset clears all outputs and aborts an op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      rsp_a_q   <= 1'b0;
      rsp_b_q   <= 1'b0;
      rdata_q   <= '0;
      inp_q     <= '0;
      sel_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
      rdata_q   <= rdata_d;
      inp_q     <= inp_d;
      sel_q     <= sel_d;
      read_q    <= read_d;
      write_q   <= write_d;
      en_q      <= en_d;
    end
  end

  // Output wiring; read and write selects always name the same register.
  always_comb begin
    a_gnt      = gnt_a_q;
    b_gnt      = gnt_b_q;
    a_rsp      = rsp_a_q;
    b_rsp      = rsp_b_q;
    rsp_rdata  = rdata_q;
    rf_inp     = inp_q;
    rf_inp_sel = sel_q;
    rf_out_sel = sel_q;
    rf_read    = read_q;
    rf_write   = write_q;
    rf_EN      = en_q;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register-file model.
module tb_regfile_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rsp, b_gnt, b_rsp;
  logic [DW-1:0] rsp_rdata, rf_inp;
  logic [DW-1:0] rf_out = '0;
  logic [5:0]    rf_inp_sel, rf_out_sel;
  logic          rf_read, rf_write, rf_EN;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [64];
  logic          init_done = 1'b0;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rsp(a_rsp),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rsp(b_rsp),
    .rsp_rdata(rsp_rdata), .rf_inp(rf_inp), .rf_inp_sel(rf_inp_sel),
    .rf_out_sel(rf_out_sel), .rf_read(rf_read), .rf_write(rf_write),
    .rf_EN(rf_EN), .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // Register file: preloaded once, writes on posedge, reads on negedge, never reset.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[31]   <= 32'hCAFEF00D;
      init_done <= 1'b1;
    end else if (rf_EN && rf_write) begin
      mem[rf_inp_sel] <= rf_inp;
    end
  end

  always @(negedge clk) begin
    if (rf_EN && rf_read) rf_out <= mem[rf_out_sel];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {a_gnt, a_rsp, b_gnt, b_rsp, rf_EN, rf_read, rf_write}
  function automatic logic [6:0] ctl();
    return {a_gnt, a_rsp, b_gnt, b_rsp, rf_EN, rf_read, rf_write};
  endfunction

  task automatic apply_reset();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    check("reset_ctl", 32'(ctl()), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
  endtask

  // Single op from idle: gnt one cycle after req, rsp one cycle after gnt, then idle.
  task automatic do_op(input string name, input bit who_b, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp_rdata);
    logic [5:0] esel;
    esel = {1'b0, addr};
    if (who_b) begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    tick();
    check({name, "_gnt"}, 32'(ctl()), 32'({!who_b, 1'b0, who_b, 1'b0, 1'b1, !we, we}));
    check({name, "_sel"}, 32'({rf_inp_sel, rf_out_sel}), 32'({esel, esel}));
    if (we) check({name, "_inp"}, rf_inp, wdata);
    a_req = 0; b_req = 0;
    tick();
    check({name, "_rsp"}, 32'(ctl()), 32'({1'b0, !who_b, 1'b0, who_b, 3'b000}));
    check({name, "_rdata"}, rsp_rdata, exp_rdata);
    tick();
    check({name, "_idle"}, 32'(ctl()), 32'd0);
  endtask

  typedef struct {
    bit            who_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Random-phase reference state
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] m_rdata;
  bit            m_last_b;
  int            since;
  int            prev_g, exp_g;
  bit            prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  bit            pend_a, pend_b, ra, rb;
  int            pick;

  initial begin
    vecs[0] = '{0, 1, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 0, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 0, 5'd31, 32'h0,        32'hCAFEF00D};
    vecs[3] = '{0, 1, 5'd31, 32'h12345678, 32'hCAFEF00D};
    vecs[4] = '{1, 0, 5'd31, 32'h0,        32'h12345678};
    vecs[5] = '{1, 1, 5'd0,  32'hA5A5A5A5, 32'h12345678};
    vecs[6] = '{0, 0, 5'd0,  32'h0,        32'hA5A5A5A5};
    vecs[7] = '{0, 0, 5'd5,  32'h0,        32'hDEADBEEF};

    // Idle after reset
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ctl", 32'(ctl()), 32'd0);
    end
    check("idle_sel", 32'({rf_inp_sel, rf_out_sel}), 32'd0);

    // Single-op table
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].who_b, vecs[i].we, vecs[i].addr,
            vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Simultaneous requests from reset: A first, then B
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 5'd1; a_wdata = 32'h11;
    b_req = 1; b_we = 1; b_addr = 5'd2; b_wdata = 32'h22;
    tick();
    check("tie_a_gnt", 32'(ctl()), 32'(7'b1000101));
    check("tie_a_inp", rf_inp, 32'h11);
    a_req = 0;
    tick();
    check("tie_a_rsp", 32'(ctl()), 32'(7'b0100000));
    tick();
    check("tie_b_gnt", 32'(ctl()), 32'(7'b0010101));
    check("tie_b_inp", rf_inp, 32'h22);
    b_req = 0;
    tick();
    check("tie_b_rsp", 32'(ctl()), 32'(7'b0001000));
    tick();
    do_op("tie_rd1", 0, 0, 5'd1, 32'h0, 32'h11);
    do_op("tie_rd2", 1, 0, 5'd2, 32'h0, 32'h22);

    // Continuous requests from both: alternating grants every other cycle
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 5'd10; a_wdata = 32'hA0;
    b_req = 1; b_we = 1; b_addr = 5'd20; b_wdata = 32'hB0;
    for (int i = 0; i < 12; i++) begin
      bit ea, eb;
      tick();
      ea = (i % 2 == 0) && ((i / 2) % 2 == 0);
      eb = (i % 2 == 0) && ((i / 2) % 2 == 1);
      check($sformatf("rr_gnt%0d", i), 32'({a_gnt, b_gnt}), 32'({ea, eb}));
      if (ea) begin a_addr = a_addr + 5'd1; a_wdata = a_wdata + 32'd1; end
      if (eb) begin b_addr = b_addr + 5'd1; b_wdata = b_wdata + 32'd1; end
    end
    a_req = 0; b_req = 0;
    tick();
    tick();
    do_op("rr_rd_a", 0, 0, 5'd12, 32'h0, 32'hA2);
    do_op("rr_rd_b", 1, 0, 5'd22, 32'h0, 32'hB2);

    // Reset in the middle of an issued write
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 5'd7; a_wdata = 32'h77;
    tick();
    check("abort_gnt", 32'(ctl()), 32'(7'b1000101));
    #2;
    rst = 1'b1;
    #1;
    check("abort_ctl", 32'(ctl()), 32'd0);
    check("abort_sel", 32'({rf_inp_sel, rf_out_sel}), 32'd0);
    check("abort_inp", rf_inp, 32'd0);
    tick();
    check("abort_no_rsp", 32'(ctl()), 32'd0);
    a_req = 0;
    rst = 1'b0;
    tick();
    check("abort_after", 32'(ctl()), 32'd0);
    do_op("abort_rd7", 0, 0, 5'd7, 32'h0, 32'h0);

    // Randomised traffic against a rule-level model
    apply_reset();
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];
    m_rdata = '0; m_last_b = 1; since = 2; prev_g = 0;
    prev_we = 0; prev_addr = '0; prev_wdata = '0;
    pend_a = 0; pend_b = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_a && $urandom_range(0, 2) != 0) begin
        pend_a = 1;
        a_we = 1'($urandom_range(0, 1));
        pick = int'($urandom_range(0, 8));
        a_addr = (pick == 8) ? 5'd31 : 5'(pick);
        a_wdata = $urandom;
      end
      if (!pend_b && $urandom_range(0, 2) != 0) begin
        pend_b = 1;
        b_we = 1'($urandom_range(0, 1));
        pick = int'($urandom_range(0, 8));
        b_addr = (pick == 8) ? 5'd31 : 5'(pick);
        b_wdata = $urandom;
      end
      a_req = pend_a;
      b_req = pend_b;
      ra = pend_a;
      rb = pend_b;
      tick();
      since++;
      if (prev_g != 0) begin
        if (prev_we) shadow[prev_addr] = prev_wdata;
        else m_rdata = shadow[prev_addr];
      end
      exp_g = 0;
      if (since >= 2) begin
        if (ra && rb) exp_g = m_last_b ? 1 : 2;
        else if (ra) exp_g = 1;
        else if (rb) exp_g = 2;
      end
      check("rnd_ctl", 32'({a_gnt, b_gnt, a_rsp, b_rsp, rf_EN}),
            32'({exp_g == 1, exp_g == 2, prev_g == 1, prev_g == 2, exp_g != 0}));
      check("rnd_rdata", rsp_rdata, m_rdata);
      if (exp_g != 0) begin
        since = 0;
        m_last_b = (exp_g == 2);
        if (exp_g == 1) begin
          prev_we = a_we; prev_addr = a_addr; prev_wdata = a_wdata; pend_a = 0;
        end else begin
          prev_we = b_we; prev_addr = b_addr; prev_wdata = b_wdata; pend_b = 0;
        end
        check("rnd_sel", 32'({rf_write, rf_read, rf_inp_sel}),
              32'({prev_we, !prev_we, 1'b0, prev_addr}));
        if (prev_we) check("rnd_inp", rf_inp, prev_wdata);
      end
      prev_g = exp_g;
    end
    a_req = 0; b_req = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
